// File: rtl/md_pkg.sv
// -----------------------------------------------------------------------------
// md_pkg
// Shared definitions for the EX-stage multiply/divide sequencer.
//   md_op_t    : HI/LO operation codes as driven on req_op
//   md_state_t : sequencer FSM states
//   DIV_ITER   : restoring-divide iteration count (one quotient bit per step)
//   is_*()     : operation classifiers; illegal codes match none of them
// -----------------------------------------------------------------------------
package md_pkg;

  localparam int DIV_ITER = 32;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MADD  = 4'd5,
    OP_MADDU = 4'd6,
    OP_MSUB  = 4'd7,
    OP_MSUBU = 4'd8,
    OP_MTHI  = 4'd9,
    OP_MTLO  = 4'd10
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } md_state_t;

  function automatic logic is_signed(md_op_t op);
    return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
  endfunction

  function automatic logic is_mul(md_op_t op);
    return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
  endfunction

  function automatic logic is_div(md_op_t op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

  function automatic logic is_acc(md_op_t op);
    return op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
  endfunction

endpackage

// File: rtl/md_divider.sv
// -----------------------------------------------------------------------------
// md_divider
// Unsigned restoring divider iterator, one quotient bit per step, MSB first.
//   clk, reset      : clock / asynchronous active-low reset
//   start           : load dividend/divisor magnitudes, clear remainder
//   step            : perform one restoring step
//   dividend,divisor: unsigned magnitudes (sampled on start)
//   quotient        : quotient after DIV_ITER steps
//   remainder       : remainder after DIV_ITER steps
//   done_iter       : high during the step that completes the last iteration
// Divide-by-zero is not special-cased here; the sequencer overrides it.
// -----------------------------------------------------------------------------
module md_divider
  import md_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        done_iter
);

  localparam logic [5:0] DIV_LAST = 6'(DIV_ITER - 1);

  logic [31:0] r_quo;
  logic [31:0] r_rem;
  logic [31:0] r_dvsr;
  logic [5:0]  r_cnt;

  // Partial remainder shifted left with the next dividend bit. The trial
  // subtraction lies strictly inside (-2^32, 2^32), so bit 32 of the 33-bit
  // difference is its sign: clear means the divisor fits.
  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic        w_fits;

  assign w_shift = {r_rem, r_quo[31]};
  assign w_diff  = w_shift - {1'b0, r_dvsr};
  assign w_fits  = ~w_diff[32];

  // NOTE: every register here, including the datapath shift registers, is in
  // the reset list so an aborted divide leaves no stale state behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_quo  <= '0;
      r_rem  <= '0;
      r_dvsr <= '0;
      r_cnt  <= '0;
    end else if (start) begin
      r_quo  <= dividend;
      r_rem  <= '0;
      r_dvsr <= divisor;
      r_cnt  <= '0;
    end else if (step) begin
      r_rem  <= w_fits ? w_diff[31:0] : w_shift[31:0];
      r_quo  <= {r_quo[30:0], w_fits};
      r_cnt  <= r_cnt + 6'd1;
    end
  end

  assign quotient  = r_quo;
  assign remainder = r_rem;
  assign done_iter = step && (r_cnt == DIV_LAST);

endmodule

// File: rtl/md_sequencer.sv
// -----------------------------------------------------------------------------
// md_sequencer
// Multi-cycle HI/LO controller for the EX-stage multiply/divide resource.
//   clk, reset          : clock / asynchronous active-low reset
//   req_valid/req_ready : one operation accepted per handshake
//   req_op              : md_op_t code (illegal codes behave as OP_NONE)
//   req_rs, req_rt      : forwarded operands
//   cancel              : flush; kills an in-flight op and blocks acceptance
//   busy                : operation in progress (MUL/DIV/FIX)
//   done                : one-cycle pulse after a mult/div/madd/msub commit
//   hi, lo              : committed HI/LO registers
// Multiply retires MUL_RADIX_BITS multiplier bits per cycle on magnitudes;
// the sign is re-applied in the single FIX cycle, which also commits.
// -----------------------------------------------------------------------------
module md_sequencer
  import md_pkg::*;
#(
  parameter int MUL_RADIX_BITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_rs,
  input  logic [31:0] req_rt,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int         MUL_ITER = 32 / MUL_RADIX_BITS;
  localparam logic [5:0] MUL_LAST = 6'(MUL_ITER - 1);

  md_state_t   r_state;
  md_op_t      r_op;
  logic        r_neg;       // multiply product sign / divide quotient sign
  logic        r_rem_neg;   // divide remainder takes the dividend sign
  logic        r_dz;        // divide by zero
  logic [31:0] r_rs_raw;
  logic [63:0] r_mcand;
  logic [31:0] r_mplier;
  logic [63:0] r_acc;
  logic [5:0]  r_mcnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_done;

  md_op_t      w_op;
  logic        w_accept;
  logic        w_sgn;
  logic [31:0] w_rs_mag;
  logic [31:0] w_rt_mag;
  logic [63:0] w_partial;
  logic [63:0] w_prod;
  logic [31:0] w_div_quo;
  logic [31:0] w_div_rem;
  logic        w_div_last;
  logic        w_div_step;

  assign w_op      = md_op_t'(req_op);
  assign req_ready = (r_state == ST_IDLE) && !cancel;
  assign w_accept  = req_valid && req_ready;

  assign w_sgn     = is_signed(w_op);
  assign w_rs_mag  = (w_sgn && req_rs[31]) ? (~req_rs + 32'd1) : req_rs;
  assign w_rt_mag  = (w_sgn && req_rt[31]) ? (~req_rt + 32'd1) : req_rt;

  assign w_partial = r_mcand * 64'(r_mplier[MUL_RADIX_BITS-1:0]);
  assign w_prod    = r_neg ? (~r_acc + 64'd1) : r_acc;

  assign w_div_step = (r_state == ST_DIV) && !cancel;

  md_divider u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (w_accept && is_div(w_op)),
    .step      (w_div_step),
    .dividend  (w_rs_mag),
    .divisor   (w_rt_mag),
    .quotient  (w_div_quo),
    .remainder (w_div_rem),
    .done_iter (w_div_last)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side reads the pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_NONE;
      r_neg     <= 1'b0;
      r_rem_neg <= 1'b0;
      r_dz      <= 1'b0;
      r_rs_raw  <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_mcnt    <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op      <= w_op;
            r_neg     <= w_sgn && (req_rs[31] ^ req_rt[31]);
            r_rem_neg <= w_sgn && req_rs[31];
            r_dz      <= (req_rt == 32'd0);
            r_rs_raw  <= req_rs;
            if (w_op == OP_MTHI) begin
              r_hi <= req_rs;
            end else if (w_op == OP_MTLO) begin
              r_lo <= req_rs;
            end else if (is_mul(w_op)) begin
              r_mcand  <= {32'd0, w_rs_mag};
              r_mplier <= w_rt_mag;
              r_acc    <= '0;
              r_mcnt   <= '0;
              r_state  <= ST_MUL;
            end else if (is_div(w_op)) begin
              r_state  <= ST_DIV;
            end
          end
        end
        ST_MUL: begin
          if (cancel) begin
            r_state <= ST_IDLE;
          end else begin
            r_acc    <= r_acc + w_partial;
            r_mcand  <= r_mcand << MUL_RADIX_BITS;
            r_mplier <= r_mplier >> MUL_RADIX_BITS;
            r_mcnt   <= r_mcnt + 6'd1;
            if (r_mcnt == MUL_LAST) r_state <= ST_FIX;
          end
        end
        ST_DIV: begin
          if (cancel)          r_state <= ST_IDLE;
          else if (w_div_last) r_state <= ST_FIX;
        end
        ST_FIX: begin
          // Flush takes priority over the commit scheduled for this edge.
          if (!cancel) begin
            r_done <= 1'b1;
            if (is_div(r_op)) begin
              if (r_dz) begin
                r_hi <= r_rs_raw;
                r_lo <= 32'hFFFF_FFFF;
              end else begin
                r_hi <= r_rem_neg ? (~w_div_rem + 32'd1) : w_div_rem;
                r_lo <= r_neg ? (~w_div_quo + 32'd1) : w_div_quo;
              end
            end else if (!is_acc(r_op)) begin
              {r_hi, r_lo} <= w_prod;
            end else if (r_op == OP_MADD || r_op == OP_MADDU) begin
              {r_hi, r_lo} <= {r_hi, r_lo} + w_prod;
            end else begin
              {r_hi, r_lo} <= {r_hi, r_lo} - w_prod;
            end
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (r_state != ST_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_md_sequencer.sv
// -----------------------------------------------------------------------------
// tb_md_sequencer
// Self-checking bench for md_sequencer. A cycle-level behavioural model
// computes each result with plain 64-bit arithmetic at accept time and counts
// down the busy latency; one negedge process compares every output to it.
// Directed scenarios pin the model with hand-computed literals; a randomized
// phase then exercises mixed ops, illegal codes, gaps and cancels.
// -----------------------------------------------------------------------------
module tb_md_sequencer;
  import md_pkg::*;

  localparam int MUL_RADIX_BITS = 8;
  localparam int MUL_LAT        = 32 / MUL_RADIX_BITS + 1;
  localparam int DIV_LAT        = 33;

  logic        clk       = 1'b0;
  logic        reset     = 1'b0;
  logic        req_valid = 1'b0;
  logic [3:0]  req_op    = 4'd0;
  logic [31:0] req_rs    = '0;
  logic [31:0] req_rt    = '0;
  logic        cancel    = 1'b0;
  logic        req_ready;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model state
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [63:0] m_res;
  int          m_left;
  logic        m_done;

  always #5 clk = ~clk;

  md_sequencer #(.MUL_RADIX_BITS(MUL_RADIX_BITS)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_rs    (req_rs),
    .req_rt    (req_rt),
    .cancel    (cancel),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of a HI/LO op given the HI/LO pair it starts from.
  function automatic logic [63:0] op_result(input logic [3:0] op, input logic [31:0] rs,
                                            input logic [31:0] rt, input logic [63:0] hilo);
    longint      sp;
    logic [63:0] p;
    longint      sq;
    longint      sr;
    sp = longint'($signed(rs)) * longint'($signed(rt));
    case (op)
      OP_MULT:  p = sp;
      OP_MADD:  p = hilo + sp;
      OP_MSUB:  p = hilo - sp;
      OP_MULTU: p = {32'd0, rs} * {32'd0, rt};
      OP_MADDU: p = hilo + {32'd0, rs} * {32'd0, rt};
      OP_MSUBU: p = hilo - {32'd0, rs} * {32'd0, rt};
      OP_DIV: begin
        if (rt == 32'd0) begin
          p = {rs, 32'hFFFF_FFFF};
        end else begin
          sq = longint'($signed(rs)) / longint'($signed(rt));
          sr = longint'($signed(rs)) % longint'($signed(rt));
          p  = {sr[31:0], sq[31:0]};
        end
      end
      OP_DIVU: p = (rt == 32'd0) ? {rs, 32'hFFFF_FFFF} : {rs % rt, rs / rt};
      default: p = hilo;
    endcase
    return p;
  endfunction

  // Behavioural model: busy for a fixed latency after accept, commit at end.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi   <= '0;
      m_lo   <= '0;
      m_res  <= '0;
      m_left <= 0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        if (cancel) begin
          m_left <= 0;
        end else if (m_left == 1) begin
          m_left       <= 0;
          {m_hi, m_lo} <= m_res;
          m_done       <= 1'b1;
        end else begin
          m_left <= m_left - 1;
        end
      end else if (req_valid && !cancel) begin
        case (req_op)
          OP_MTHI: m_hi <= req_rs;
          OP_MTLO: m_lo <= req_rs;
          OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
            m_res  <= op_result(req_op, req_rs, req_rt, {m_hi, m_lo});
            m_left <= MUL_LAT;
          end
          OP_DIV, OP_DIVU: begin
            m_res  <= op_result(req_op, req_rs, req_rt, {m_hi, m_lo});
            m_left <= DIV_LAT;
          end
          default: ;
        endcase
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 64'(busy), 64'(m_left > 0));
      check("done", 64'(done), 64'(m_done));
      check("hi", 64'(hi), 64'(m_hi));
      check("lo", 64'(lo), 64'(m_lo));
      check("req_ready", 64'(req_ready), 64'((m_left == 0) && !cancel));
    end
  end

  // Issue one op (called shortly after a posedge), count busy cycles, then
  // check the literal results. Returns shortly after a posedge.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input int exp_busy,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cnt   = 0;
    bit ended = 1'b0;
    req_valid = 1'b1;
    req_op    = op;
    req_rs    = rs;
    req_rt    = rt;
    @(posedge clk);
    #2 req_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin
        ended = 1'b1;
        break;
      end
      cnt++;
    end
    if (!ended) check({name, "_busy_bound"}, 64'(busy), 64'd0);
    check({name, "_busy_cycles"}, 64'(cnt), 64'(exp_busy));
    check({name, "_done"}, 64'(done), 64'd1);
    check({name, "_hi"}, 64'(hi), 64'(exp_hi));
    check({name, "_lo"}, 64'(lo), 64'(exp_lo));
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd1);
    reset  = 1'b1;
    chk_en = 1'b1;
    @(posedge clk);
    #2;

    // Multiply family
    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("madd", OP_MADD, 32'd2, 32'd3, 5, 32'hFFFF_FFFE, 32'h0000_0007);
    run_op("msubu", OP_MSUBU, 32'd7, 32'd1, 5, 32'hFFFF_FFFE, 32'h0000_0000);

    // Divide family
    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_zero", OP_DIVU, 32'd7, 32'd0, 33, 32'd7, 32'hFFFF_FFFF);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);
    run_op("div_zero_s", OP_DIV, 32'hFFFF_FFF0, 32'd0, 33, 32'hFFFF_FFF0, 32'hFFFF_FFFF);

    // Back-to-back MTHI / MTLO
    req_valid = 1'b1;
    req_op    = OP_MTHI;
    req_rs    = 32'h1234_5678;
    @(posedge clk);
    #2;
    req_op = OP_MTLO;
    req_rs = 32'h0000_ABCD;
    @(negedge clk);
    check("mthi_hi", 64'(hi), 64'h1234_5678);
    check("mthi_busy", 64'(busy), 64'd0);
    check("mthi_done", 64'(done), 64'd0);
    @(posedge clk);
    #2 req_valid = 1'b0;
    @(negedge clk);
    check("mtlo_lo", 64'(lo), 64'h0000_ABCD);
    @(posedge clk);
    #2;

    // Cancel during divide
    req_valid = 1'b1;
    req_op    = OP_MTHI;
    req_rs    = 32'h55;
    @(posedge clk);
    #2 req_op = OP_MTLO;
    @(posedge clk);
    #2;
    req_op = OP_DIV;
    req_rs = 32'd1000;
    req_rt = 32'd7;
    @(posedge clk);
    #2 req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 cancel = 1'b1;
    @(posedge clk);
    #2 cancel = 1'b0;
    @(negedge clk);
    check("cancel_busy", 64'(busy), 64'd0);
    check("cancel_done", 64'(done), 64'd0);
    check("cancel_hilo", {32'(hi), 32'(lo)}, {32'h55, 32'h55});
    run_op("mult_after_cancel", OP_MULT, 32'd6, 32'd7, 5, 32'd0, 32'd42);

    // Cancel in IDLE blocks acceptance
    cancel    = 1'b1;
    req_valid = 1'b1;
    req_op    = OP_MTHI;
    req_rs    = 32'hDEAD_BEEF;
    @(negedge clk);
    check("idle_cancel_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #2;
    cancel    = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check("idle_cancel_hi", 64'(hi), 64'd0);
    @(posedge clk);
    #2;

    // Cancel during the FIX cycle beats the commit
    req_valid = 1'b1;
    req_op    = OP_MULT;
    req_rs    = 32'd9;
    req_rt    = 32'd9;
    @(posedge clk);
    #2 req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 cancel = 1'b1;
    @(posedge clk);
    #2 cancel = 1'b0;
    @(negedge clk);
    check("fix_cancel_lo", 64'(lo), 64'd42);
    check("fix_cancel_done", 64'(done), 64'd0);
    check("fix_cancel_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #2;

    // Reset in the middle of a divide
    req_valid = 1'b1;
    req_op    = OP_DIV;
    req_rs    = 32'd100;
    req_rt    = 32'd3;
    @(posedge clk);
    #2 req_valid = 1'b0;
    repeat (19) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    check("postrst_ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    #2;
    run_op("mult_after_rst", OP_MULT, 32'd4, 32'd5, 5, 32'd0, 32'd20);

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      req_valid = ($urandom_range(0, 2) != 0);
      req_op    = 4'($urandom_range(0, 15));
      req_rs    = pick_operand();
      req_rt    = pick_operand();
      cancel    = ($urandom_range(0, 59) == 0);
      @(posedge clk);
      #2;
    end
    req_valid = 1'b0;
    cancel    = 1'b0;
    for (int i = 0; i < 100 && m_left > 0; i++) begin
      @(posedge clk);
      #2;
    end
    check("drain_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Multi-cycle controller for the multiply/divide resource in EX; replaces the fixed delay-counter model with a real iterative datapath.
- Accepts one HI/LO operation per handshake from the EX-stage issue logic.
- Sequences an iterative multiplier (MUL_RADIX_BITS bits/cycle) or a restoring divider (1 bit/cycle), then commits HI/LO.
- Exposes busy, so hazard logic can stall MFHI/MFLO and new mult/div, and cancel, so exception flush can kill an in-flight operation.

Parameters:
- MUL_RADIX_BITS, 8, multiplier bits retired per cycle; legal values 1, 2, 4, 8, 16, 32.
- MUL_ITER, 32/MUL_RADIX_BITS, derived localparam; multiply iteration cycles.
- DIV_ITER, 32, fixed localparam; divide iteration cycles.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset.
- req_valid  in  1  EX offers an operation.
- req_ready  out  1  sequencer can accept this cycle.
- req_op  in  4  operation code from md_pkg.
- req_rs  in  32  forwarded rs operand.
- req_rt  in  32  forwarded rt operand.
- cancel  in  1  flush; kills the in-flight op and blocks acceptance.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse after a mult/div/madd/msub commit.
- hi  out  32  committed HI.
- lo  out  32  committed LO.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, hi=0, lo=0, done=0, all iteration registers cleared.
  - Applies mid-operation too; the in-flight op is lost.
- req_ready = (state==IDLE) && !cancel. Accept occurs on the edge where req_valid && req_ready.
- OP_NONE accepted: no effect.
- OP_MTHI / OP_MTLO:
  - hi<=req_rs or lo<=req_rs on the accept edge.
  - State stays IDLE; busy never asserts; no done.
- MULT, MULTU, MADD, MADDU, MSUB, MSUBU:
  - Latch operand magnitudes (absolute value for signed ops; raw for U ops), result-sign flag and op; state->MUL.
  - MUL: runs MUL_ITER cycles. Each cycle, acc64 += mcand64 * rt_slice; mcand shifts left MUL_RADIX_BITS; rt shifts right MUL_RADIX_BITS. Then ->FIX.
  - FIX: 1 cycle. Negate acc64 if the sign flag is set (64-bit two's complement). Commit:
    - MULT/MULTU: {hi,lo} <= acc.
    - MADD/MADDU: {hi,lo} <= {hi,lo}+acc.
    - MSUB/MSUBU: {hi,lo} <= {hi,lo}-acc.
    - All modulo 2^64.
  - Commit happens on FIX's closing edge; state->IDLE.
- DIV, DIVU:
  - Latch magnitudes; state->DIV.
  - DIV: DIV_ITER restoring steps, 1 quotient bit per cycle, MSB first. Then FIX.
  - FIX: quotient negated if operand signs differ (signed only); remainder takes the dividend sign. hi<=remainder, lo<=quotient.
  - Divide by zero (rt==0, signed or unsigned): hi<=req_rs, lo<=32'hFFFFFFFF; still takes the full DIV_ITER+1 cycles.
  - 0x80000000 / 0xFFFFFFFF (DIV): lo=0x80000000, hi=0.
- Latency, accept edge to commit edge:
  - Multiply: MUL_ITER+1 cycles (5 at default).
  - Divide: 33 cycles.
  - busy is high exactly those cycles.
  - done is high the single cycle after the commit edge; the sequencer may accept a new op in that same cycle.
- hi/lo always show committed values; they hold old values while busy.
- cancel while busy: state->IDLE on the next edge; hi/lo unchanged; no done.
- cancel in the FIX cycle wins over commit.
- cancel in IDLE: blocks acceptance only.
- Illegal req_op codes are treated as OP_NONE.

Decomposition:
- md_pkg (shared):
  - md_op_t encoding: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MADD=5, MADDU=6, MSUB=7, MSUBU=8, MTHI=9, MTLO=10.
  - md_state_t: IDLE, MUL, DIV, FIX.
  - Helper classifiers: is_signed(op), is_mul(op), is_div(op), is_acc(op).
  - DIV_ITER constant.
- One sub-module, md_divider: restoring-step iterator holding the remainder/quotient shift registers, with start, step and done_iter. The multiply iterator and FSM stay in md_sequencer.

Test Plan:
- MULT rs=0xFFFFFFFE (-2), rt=3: busy for 5 cycles, then done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then MADD rs=2, rt=3 -> lo=0x00000007, hi unchanged.
- DIV rs=-7 (0xFFFFFFF9), rt=2: busy 33 cycles -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=7, rt=0 -> hi=7, lo=0xFFFFFFFF.
- MTHI rs=0x12345678 in IDLE -> hi=0x12345678 on the next edge; busy stays 0; done stays 0. Back-to-back MTLO the following cycle is accepted.
- DIV started with hi=lo=0x55: assert cancel at iteration 10 -> IDLE next edge, hi=lo=0x55, no done; a new MULT is accepted the cycle after cancel deasserts.
- Drive reset low mid-DIV (cycle 20) -> hi=lo=0 and busy=0 immediately. After release, req_ready=1 and MULT 4*5 gives lo=20.
